// File: rtl/mult_div_unit.sv
// Sequential signed 32-bit multiply / divide unit.
//
// One operation at a time, 32 clock iterations each, followed by a single
// result-valid cycle. A start (ctrl_MULT or ctrl_DIV high at a rising edge)
// is accepted from any state and aborts whatever is in flight.
//
// Ports:
//   clock          rising-edge clock
//   reset          synchronous active-high reset
//   data_operandA  signed multiplicand / dividend, sampled on a start edge
//   data_operandB  signed multiplier / divisor, sampled on a start edge
//   ctrl_MULT      start a multiply (wins over ctrl_DIV)
//   ctrl_DIV       start a divide
//   data_result    low 32 bits of the product, or the quotient
//   data_exception multiply overflow or divide fault, valid with data_resultRDY
//   data_resultRDY one-cycle result-valid pulse
module mult_div_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_MULT,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [5:0]  count_q;
  logic [31:0] op_a_q, op_b_q;
  // Multiply: running 64-bit sum. Divide: {remainder, dividend/quotient}.
  logic [63:0] acc_q;
  // Sign-extended multiplicand, shifted left once per iteration.
  logic [63:0] mcand_q;
  logic [31:0] result_q;
  logic        exc_q;

  logic        start;
  logic        last;
  logic [31:0] a_mag_in;

  // Multiply step
  logic [63:0] addend;
  logic [63:0] prod_next;
  logic [31:0] mul_res;
  logic        mul_exc;

  // Divide step
  logic [31:0] divisor_mag;
  logic [32:0] trial;
  logic [32:0] diff;
  logic [63:0] div_next;
  logic [31:0] quot;
  logic [31:0] div_res;
  logic        div_exc;

  assign start    = ctrl_MULT | ctrl_DIV;
  assign last     = (count_q == 6'd31);
  assign a_mag_in = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = ctrl_MULT ? StMul : StDiv;
    end else begin
      case (state_q)
        StIdle:       state_d = StIdle;
        StMul, StDiv: if (last) state_d = StDone;
        StDone:       state_d = StIdle;
        default:      state_d = StIdle;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    data_resultRDY = (state_q == StDone);
    data_result    = result_q;
    data_exception = exc_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    // Bit 31 of a two's-complement multiplier weighs -2^31, so the last
    // partial product is subtracted rather than added.
    addend    = op_b_q[count_q[4:0]] ? mcand_q : 64'd0;
    prod_next = last ? (acc_q - addend) : (acc_q + addend);
    mul_res   = prod_next[31:0];
    mul_exc   = !((&prod_next[63:31]) || (~|prod_next[63:31]));
  end

  always_comb begin
    divisor_mag = op_b_q[31] ? (32'd0 - op_b_q) : op_b_q;
    // Restoring step: shift next dividend bit into the remainder and try
    // to subtract the divisor magnitude.
    trial       = {acc_q[63:32], acc_q[31]};
    diff        = trial - {1'b0, divisor_mag};
    if (diff[32]) begin
      div_next = {trial[31:0], acc_q[30:0], 1'b0};
    end else begin
      div_next = {diff[31:0], acc_q[30:0], 1'b1};
    end
    quot = div_next[31:0];
    if (op_b_q == 32'd0) begin
      div_res = 32'd0;
      div_exc = 1'b1;
    end else if (op_a_q == 32'h8000_0000 && op_b_q == 32'hFFFF_FFFF) begin
      // Magnitude quotient is already 0x80000000 and the signs cancel.
      div_res = quot;
      div_exc = 1'b1;
    end else begin
      div_res = (op_a_q[31] ^ op_b_q[31]) ? (32'd0 - quot) : quot;
      div_exc = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q  <= 6'd0;
      op_a_q   <= 32'd0;
      op_b_q   <= 32'd0;
      acc_q    <= 64'd0;
      mcand_q  <= 64'd0;
      result_q <= 32'd0;
      exc_q    <= 1'b0;
    end else if (start) begin
      count_q <= 6'd0;
      op_a_q  <= data_operandA;
      op_b_q  <= data_operandB;
      mcand_q <= {{32{data_operandA[31]}}, data_operandA};
      acc_q   <= ctrl_MULT ? 64'd0 : {32'd0, a_mag_in};
    end else if (state_q == StMul) begin
      acc_q   <= prod_next;
      mcand_q <= {mcand_q[62:0], 1'b0};
      count_q <= last ? 6'd0 : count_q + 6'd1;
      if (last) begin
        result_q <= mul_res;
        exc_q    <= mul_exc;
      end
    end else if (state_q == StDiv) begin
      acc_q   <= div_next;
      count_q <= last ? 6'd0 : count_q + 6'd1;
      if (last) begin
        result_q <= div_res;
        exc_q    <= div_exc;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int checks = 0;
  int errors = 0;

  mult_div_unit dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  // Reference result {exception, result} from plain signed arithmetic.
  function automatic logic [32:0] ref_op(input logic is_mul, input logic [31:0] x,
                                         input logic [31:0] y);
    logic [63:0] p;
    logic [32:0] hi;
    int          q;
    if (is_mul) begin
      p  = longint'($signed(x)) * longint'($signed(y));
      hi = p[63:31];
      return {(hi != '0) && (hi != '1), p[31:0]};
    end else if (y == 32'd0) begin
      return {1'b1, 32'd0};
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      return {1'b1, 32'h8000_0000};
    end else begin
      q = $signed(x) / $signed(y);
      return {1'b0, 32'(q)};
    end
  endfunction

  // Model state: a start schedules a result 32 edges later; reset or a
  // newer start discards it.
  logic        m_pending = 1'b0;
  int          m_rem = 0;
  logic        m_rdy = 1'b0;
  logic [31:0] m_res = 32'd0;
  logic        m_exc = 1'b0;
  logic [31:0] p_res = 32'd0;
  logic        p_exc = 1'b0;

  always @(posedge clock) begin : model
    logic [32:0] r;
    if (reset) begin
      m_pending <= 1'b0;
      m_rdy     <= 1'b0;
      m_res     <= 32'd0;
      m_exc     <= 1'b0;
      m_rem     <= 0;
    end else if (ctrl_MULT || ctrl_DIV) begin
      r = ref_op(ctrl_MULT, data_operandA, data_operandB);
      p_res     <= r[31:0];
      p_exc     <= r[32];
      m_pending <= 1'b1;
      m_rem     <= 32;
      m_rdy     <= 1'b0;
    end else if (m_pending) begin
      if (m_rem == 1) begin
        m_pending <= 1'b0;
        m_rdy     <= 1'b1;
        m_res     <= p_res;
        m_exc     <= p_exc;
      end
      m_rem <= m_rem - 1;
    end else begin
      m_rdy <= 1'b0;
    end
  end

  // Hand-computed expectation for the operation currently being run.
  logic        lit_valid = 1'b0;
  logic [31:0] lit_res = 32'd0;
  logic        lit_exc = 1'b0;
  logic        pinned = 1'b0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (!pinned) begin
      chk("model 6*7", ref_op(1'b1, 32'd6, 32'd7), {1'b0, 32'd42});
      chk("model -3*5", ref_op(1'b1, 32'hFFFF_FFFD, 32'd5), {1'b0, 32'hFFFF_FFF1});
      chk("model ovf", ref_op(1'b1, 32'h0001_0000, 32'h0001_0000), {1'b1, 32'd0});
      chk("model -7/2", ref_op(1'b0, 32'hFFFF_FFF9, 32'd2), {1'b0, 32'hFFFF_FFFD});
      chk("model 100/-10", ref_op(1'b0, 32'd100, 32'hFFFF_FFF6), {1'b0, 32'hFFFF_FFF6});
      chk("model 5/0", ref_op(1'b0, 32'd5, 32'd0), {1'b1, 32'd0});
      chk("model minint/-1", ref_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF),
          {1'b1, 32'h8000_0000});
      pinned = 1'b1;
    end
    chk("resultRDY", 33'(data_resultRDY), 33'(m_rdy));
    if (!m_pending) begin
      chk("result", 33'(data_result), 33'(m_res));
      chk("exception", 33'(data_exception), 33'(m_exc));
    end
    if (data_resultRDY && lit_valid) begin
      chk("literal", {data_exception, data_result}, {lit_exc, lit_res});
    end
  end

  // Idle cycles with operand noise that must be ignored.
  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      data_operandA = $urandom;
      data_operandB = $urandom;
    end
  endtask

  task automatic start_op(input logic m, input logic d, input logic [31:0] x,
                          input logic [31:0] y, input logic lv, input logic [31:0] lr,
                          input logic le);
    @(negedge clock);
    data_operandA = x;
    data_operandB = y;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    lit_valid     = lv;
    lit_res       = lr;
    lit_exc       = le;
    @(negedge clock);
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return $urandom_range(0, 300);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    idle(5);

    start_op(1'b1, 1'b0, 32'd6, 32'd7, 1'b1, 32'd42, 1'b0);
    idle(36);
    start_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, 1'b1, 32'hFFFF_FFF1, 1'b0);
    idle(36);
    start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b1, 32'd0, 1'b1);
    idle(36);
    start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 1'b0);
    idle(36);
    start_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF6, 1'b1, 32'hFFFF_FFF6, 1'b0);
    idle(36);
    start_op(1'b0, 1'b1, 32'd5, 32'd0, 1'b1, 32'd0, 1'b1);
    idle(36);
    start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 1'b1);
    idle(36);

    // Restart: divide aborted by a multiply ten cycles later.
    start_op(1'b0, 1'b1, 32'd9, 32'd3, 1'b0, 32'd0, 1'b0);
    idle(9);
    start_op(1'b1, 1'b0, 32'd4, 32'd4, 1'b1, 32'd16, 1'b0);
    idle(36);

    // Both controls high: multiply wins.
    start_op(1'b1, 1'b1, 32'd8, 32'd2, 1'b1, 32'd16, 1'b0);
    idle(36);

    // Reset in the middle of a multiply.
    start_op(1'b1, 1'b0, 32'd123, 32'd456, 1'b0, 32'd0, 1'b0);
    idle(13);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    idle(40);

    for (int i = 0; i < 60; i++) begin
      int op;
      int hold;
      int gap;
      op   = $urandom_range(0, 2);
      hold = ($urandom_range(0, 5) == 0) ? $urandom_range(2, 4) : 1;
      for (int h = 0; h < hold; h++) begin
        @(negedge clock);
        data_operandA = pick();
        data_operandB = pick();
        ctrl_MULT     = (op != 1);
        ctrl_DIV      = (op != 0);
        lit_valid     = 1'b0;
      end
      @(negedge clock);
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 31) : $urandom_range(32, 38);
      if ($urandom_range(0, 15) == 0) begin
        idle($urandom_range(1, 20));
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
      end
      idle(gap);
    end

    idle(40);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
